line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//   Main-memory responder for the data cache's line-refill/write-back port.
//   Accepts one 128-bit line transaction at a time over the mem_req/mem_ready handshake.
//   Services it after a fixed, parameterised latency from a line-organised backing array.
//   Sits below the cache in the memory stage, replacing the zero-wait memory model.
// PARAMETERS
//   LINE_WIDTH   128        bits per line; byte offset = $clog2(LINE_WIDTH/8) = 4 bits
//   DEPTH_LINES  4096       lines in backing array; IDX_BITS = $clog2(DEPTH_LINES)
//   LATENCY      4          cycles from request acceptance to mem_ready; legal range >= 1
//   INIT_FILE    ""         $readmemh image loaded into the array at time 0 when non-empty
// PORTS
//   clk             in   1           clock, all state updates on rising edge
//   rst             in   1           asynchronous reset, active-high
//   mem_req         in   1           transaction request from cache
//   WriteEnable     in   1           1 = line write, 0 = line read; qualified by mem_req
//   memory_address  in   32          byte address; low 4 bits ignored
//   mem_writedata   in   LINE_WIDTH  line to write
//   mem_readdata    out  LINE_WIDTH  line returned for reads; registered
//   mem_ready       out  1           one-cycle completion pulse
//   busy            out  1           high while a transaction is outstanding (WAIT or RESP)
// BEHAVIOUR
//   FSM states: IDLE, WAIT, RESP.
//   - IDLE: on an edge with mem_req=1, latch index = memory_address[4 +: IDX_BITS].
//     Also latch WriteEnable and mem_writedata, load cnt = LATENCY-1.
//     Go to WAIT, or to RESP directly when LATENCY==1.
//   - WAIT: cnt decrements each edge; on the edge where cnt==1 go to RESP.
//   - RESP: mem_ready=1 for exactly this cycle, then IDLE unconditionally.
//   - Read path: the edge entering RESP loads mem_readdata <= array[index].
//   - Write path: the edge entering RESP performs array[index] <= latched data.
//     mem_readdata is NOT updated on writes; it holds its last read value.
//   Timing:
//   - mem_ready is high in the cycle that starts LATENCY edges after the accepting edge.
//   - mem_readdata is valid in that same cycle and stable until the next read completes.
//   Handshake rules:
//   - The requester drops mem_req in the cycle after seeing mem_ready.
//   - mem_req=1 sampled in IDLE always starts a new transaction; back-to-back spacing is LATENCY+1 edges.
//   - Inputs are captured only at acceptance; changes to address/data/WriteEnable/mem_req
//     during WAIT/RESP are ignored.
//   - A transaction whose mem_req drops early still completes and still pulses mem_ready.
//   Addressing:
//   - Address bits above 4+IDX_BITS are ignored, so addresses alias modulo DEPTH_LINES*16 bytes.
//   - Offset bits [3:0] never select within a line.
//   Reset (async, any state):
//   - state=IDLE, cnt=0, mem_ready=0, busy=0, mem_readdata=0.
//   - An in-flight write is discarded; the array is not written.
//   - Array contents are preserved; INIT_FILE is not reloaded.
//   - Reset deasserting with mem_req=1: the first edge after release accepts the request.
//   busy = (state != IDLE); combinational from state, 0 in reset.
// TESTING
//   1. rst pulse mid-run in IDLE -> mem_ready=0, busy=0, mem_readdata=0 immediately (async), no clock needed.
//   2. LATENCY=4, INIT line 0x10 = 0xA5.., read addr 0x0000_0100 -> mem_ready one cycle, 4 edges after accept; mem_readdata=0xA5..; busy high 4 cycles.
//   3. Write 0xDEADBEEF_..._0001 to 0x200, then read 0x20C -> read returns written line; mem_readdata unchanged during the write's RESP.
//   4. Read 0x0001_0100 with DEPTH_LINES=4096 -> same data as 0x100 (alias); toggle address and mem_req during WAIT -> no effect.
//   5. Write to 0x300 (old=X0), assert rst during WAIT -> no mem_ready; subsequent read of 0x300 returns X0.
//   6. LATENCY=1, req held continuously with alternating read/write -> ready every 2nd cycle, each op serviced once in order.

Source files
------------

// File: rtl/line_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder_if
// Description : Line-transaction bus between the data cache (master) and the
//               main-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface line_mem_responder_if #(
   parameter int LINE_WIDTH = 128
);
   logic                  mem_req;
   logic                  WriteEnable;
   logic [31:0]           memory_address;
   logic [LINE_WIDTH-1:0] mem_writedata;
   logic [LINE_WIDTH-1:0] mem_readdata;
   logic                  mem_ready;
   logic                  busy;

   // Cache side: issues requests, consumes completions
   modport master (
      output mem_req,
      output WriteEnable,
      output memory_address,
      output mem_writedata,
      input  mem_readdata,
      input  mem_ready,
      input  busy
   );

   // Memory side: accepts requests, produces completions
   modport slave (
      input  mem_req,
      input  WriteEnable,
      input  memory_address,
      input  mem_writedata,
      output mem_readdata,
      output mem_ready,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Fixed-latency main-memory responder for cache line refills and
//               write-backs. One transaction in flight; line-organised array.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
   parameter int    LINE_WIDTH  = 128,
   parameter int    DEPTH_LINES = 4096,
   parameter int    LATENCY     = 4,
   parameter string INIT_FILE   = ""
) (
   input  logic                     clk,
   input  logic                     rst,
   line_mem_responder_if.slave      bus
);

   localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
   localparam int IDX_BITS = $clog2(DEPTH_LINES);
   // Counter only needs to hold LATENCY-1
   localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [CNT_W-1:0]      cnt;
   logic [IDX_BITS-1:0]   idx_q;
   logic                  we_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic [LINE_WIDTH-1:0] readdata_q;

   logic [LINE_WIDTH-1:0] mem_array [DEPTH_LINES];

   logic                  accept;
   logic                  enter_resp;
   logic [IDX_BITS-1:0]   op_idx;
   logic                  op_we;
   logic [LINE_WIDTH-1:0] op_wdata;
   logic                  unused_addr_bits;

   // Only the line index participates; offset and high bits alias away
   assign unused_addr_bits = ^{bus.memory_address[31:OFF_BITS+IDX_BITS],
                               bus.memory_address[OFF_BITS-1:0]};

   assign accept     = (state == IDLE) && bus.mem_req;
   assign enter_resp = (accept && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == CNT_ONE));

   // With LATENCY==1 the array access happens on the accepting edge itself,
   // so the live inputs must be used instead of the not-yet-latched copies.
   assign op_idx   = (state == IDLE) ? bus.memory_address[OFF_BITS +: IDX_BITS] : idx_q;
   assign op_we    = (state == IDLE) ? bus.WriteEnable   : we_q;
   assign op_wdata = (state == IDLE) ? bus.mem_writedata : wdata_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (bus.mem_req) next_state = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == CNT_ONE) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request capture, latency countdown and read-data register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx_q      <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         readdata_q <= '0;
      end else begin
         if (accept) begin
            cnt     <= CNT_LOAD;
            idx_q   <= bus.memory_address[OFF_BITS +: IDX_BITS];
            we_q    <= bus.WriteEnable;
            wdata_q <= bus.mem_writedata;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
         end
         if (enter_resp && !op_we) readdata_q <= mem_array[op_idx];
      end
   end

   // Array write; rst guard drops a write that would coincide with reset
   always_ff @(posedge clk) begin
      if (enter_resp && op_we && !rst) mem_array[op_idx] <= op_wdata;
   end

   assign bus.mem_readdata = readdata_q;
   assign bus.mem_ready    = (state == RESP);
   assign bus.busy         = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Directed self-checking bench for line_mem_responder; one
//               LATENCY=4 instance and one LATENCY=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   line_mem_responder_if #(.LINE_WIDTH(128)) bus4 ();
   line_mem_responder_if #(.LINE_WIDTH(128)) bus1 ();

   line_mem_responder #(.LINE_WIDTH(128), .DEPTH_LINES(4096), .LATENCY(4), .INIT_FILE(""))
      dut4 (.clk(clk), .rst(rst), .bus(bus4));

   line_mem_responder #(.LINE_WIDTH(128), .DEPTH_LINES(16), .LATENCY(1), .INIT_FILE(""))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // One comparison point
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transaction on the LATENCY=4 instance; lat counts edges with the
   // accepting edge as 1, -1 if mem_ready never came within the bound.
   task automatic txn4(input logic we, input logic [31:0] addr, input logic [127:0] data,
                       input bit toggle, output int lat, output int busy_n,
                       output logic [127:0] rd);
      bus4.mem_req        = 1'b1;
      bus4.WriteEnable    = we;
      bus4.memory_address = addr;
      bus4.mem_writedata  = data;
      lat    = -1;
      busy_n = 0;
      rd     = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (bus4.busy) busy_n++;
         if (bus4.mem_ready) begin
            lat = n;
            rd  = bus4.mem_readdata;
            break;
         end
         if (toggle) begin
            bus4.mem_req        = ~bus4.mem_req;
            bus4.WriteEnable    = ~bus4.WriteEnable;
            bus4.memory_address = 32'h0000_0200;
            bus4.mem_writedata  = '0;
         end
      end
      bus4.mem_req     = 1'b0;
      bus4.WriteEnable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [127:0] a5, dead, x0, d1, d2, d3, rd;
      int lat, busy_n, ready_seen;

      a5   = {16{8'hA5}};
      dead = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000001};
      x0   = {8{16'h5A3C}};
      d1   = {4{32'h1111_0001}};
      d2   = {4{32'h2222_0002}};
      d3   = {4{32'h3333_0003}};

      bus4.mem_req = 1'b0; bus4.WriteEnable = 1'b0; bus4.memory_address = '0; bus4.mem_writedata = '0;
      bus1.mem_req = 1'b0; bus1.WriteEnable = 1'b0; bus1.memory_address = '0; bus1.mem_writedata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 128'(bus4.mem_ready), 128'd0);
      chk("rst_busy", 128'(bus4.busy), 128'd0);
      chk("rst_rdata", bus4.mem_readdata, 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Preload line 0x10; write must not disturb mem_readdata
      txn4(1'b1, 32'h0000_0100, a5, 1'b0, lat, busy_n, rd);
      chk("wr100_lat", 128'(lat), 128'd4);
      chk("wr100_rdata_hold", rd, 128'd0);

      // Read latency, busy window, data
      txn4(1'b0, 32'h0000_0100, '0, 1'b0, lat, busy_n, rd);
      chk("rd100_lat", 128'(lat), 128'd4);
      chk("rd100_busy_cycles", 128'(busy_n), 128'd4);
      chk("rd100_data", rd, a5);
      chk("rd100_idle_busy", 128'(bus4.busy), 128'd0);
      chk("rd100_data_stable", bus4.mem_readdata, a5);

      // Write then read same line at another offset
      txn4(1'b1, 32'h0000_0200, dead, 1'b0, lat, busy_n, rd);
      chk("wr200_rdata_hold", rd, a5);
      txn4(1'b0, 32'h0000_020C, '0, 1'b0, lat, busy_n, rd);
      chk("rd20C_data", rd, dead);

      // Asynchronous reset pulse in IDLE, no clock edge involved
      #2; rst = 1'b1; #1;
      chk("apulse_ready", 128'(bus4.mem_ready), 128'd0);
      chk("apulse_busy", 128'(bus4.busy), 128'd0);
      chk("apulse_rdata", bus4.mem_readdata, 128'd0);
      #1; rst = 1'b0;
      @(posedge clk); #1;

      // Alias read with inputs churning during WAIT
      txn4(1'b0, 32'h0001_0100, '0, 1'b1, lat, busy_n, rd);
      chk("alias_lat", 128'(lat), 128'd4);
      chk("alias_data", rd, a5);
      txn4(1'b0, 32'h0000_0200, '0, 1'b0, lat, busy_n, rd);
      chk("rd200_after_churn", rd, dead);

      // Reset during an in-flight write discards it
      txn4(1'b1, 32'h0000_0300, x0, 1'b0, lat, busy_n, rd);
      bus4.mem_req = 1'b1; bus4.WriteEnable = 1'b1;
      bus4.memory_address = 32'h0000_0300; bus4.mem_writedata = '1;
      @(posedge clk); #1;
      bus4.mem_req = 1'b0; bus4.WriteEnable = 1'b0;
      chk("wr300b_busy", 128'(bus4.busy), 128'd1);
      @(posedge clk); #2;
      rst = 1'b1; #1;
      chk("midrst_ready", 128'(bus4.mem_ready), 128'd0);
      chk("midrst_busy", 128'(bus4.busy), 128'd0);
      chk("midrst_rdata", bus4.mem_readdata, 128'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      ready_seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus4.mem_ready) ready_seen++;
      end
      chk("midrst_no_ready", 128'(ready_seen), 128'd0);
      txn4(1'b0, 32'h0000_0300, '0, 1'b0, lat, busy_n, rd);
      chk("rd300_old", rd, x0);

      // LATENCY=1, request held: W1 R1 W2 R2 W1' R1
      for (int k = 0; k < 6; k++) begin
         logic [127:0] wd;
         logic [127:0] exp_rd;
         logic [3:0]   line;
         line   = (k == 2 || k == 3) ? 4'd2 : 4'd1;
         wd     = (k == 0) ? d1 : (k == 2) ? d2 : d3;
         exp_rd = (k == 1) ? d1 : (k == 3) ? d2 : (k == 5) ? d3 : d2;
         bus1.mem_req        = 1'b1;
         bus1.WriteEnable    = (k % 2 == 0);
         bus1.memory_address = {24'h0, line, 4'(k)};
         bus1.mem_writedata  = wd;
         @(posedge clk); #1;
         chk($sformatf("l1_op%0d_ready", k), 128'(bus1.mem_ready), 128'd1);
         if (k % 2 == 1 || k == 4)
            chk($sformatf("l1_op%0d_rdata", k), bus1.mem_readdata, exp_rd);
         @(posedge clk); #1;
         chk($sformatf("l1_op%0d_gap", k), 128'(bus1.mem_ready), 128'd0);
      end
      bus1.mem_req = 1'b0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
